// File: rtl/stream_rr_sched.sv
// stream_rr_sched: round-robin scheduler merging N_INP valid/ready streams into one output stream.
//
// Ports:
//   clk_i        clock; all state updates on its rising edge
//   rst_i        asynchronous active-high reset
//   inp_data_i   per-input payloads (N_INP x DATA_T)
//   inp_valid_i  per-input valid
//   inp_ready_o  per-input ready; only the selected input sees oup_ready_i
//   oup_data_o   payload of the selected input
//   oup_valid_o  valid of the selected input
//   oup_ready_i  downstream ready
//   oup_idx_o    index of the selected input
//
// Build option: define STREAM_RR_SCHED_LOCK_EN to hold a stalled grant (LOCKED state)
// until it completes. Without it the selection is re-arbitrated every cycle.
module stream_rr_sched #(
    parameter type DATA_T = logic,
    parameter int  N_INP  = 2,
    parameter int  IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  DATA_T            inp_data_i [N_INP],
    input  logic [N_INP-1:0] inp_valid_i,
    output logic [N_INP-1:0] inp_ready_o,
    output DATA_T            oup_data_o,
    output logic             oup_valid_o,
    input  logic             oup_ready_i,
    output logic [IDX_W-1:0] oup_idx_o
);
    logic [IDX_W-1:0] rr_q, rr_d, sel, cand;
    logic             found, hs;
`ifdef STREAM_RR_SCHED_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_e;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

    always_comb begin
        sel   = rr_q;
        cand  = rr_q;
        found = 1'b0;
        // Search from the priority pointer upward with wrap; first valid wins.
        for (int i = 0; i < N_INP; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % N_INP);
            if (!found && inp_valid_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
`ifdef STREAM_RR_SCHED_LOCK_EN
        if (state_q == LOCKED) sel = lock_idx_q;
`endif
        oup_idx_o        = sel;
        oup_data_o       = inp_data_i[sel];
        oup_valid_o      = inp_valid_i[sel];
        inp_ready_o      = '0;
        inp_ready_o[sel] = oup_ready_i;
        hs               = oup_valid_o & oup_ready_i;
        rr_d             = !hs ? rr_q : (sel == IDX_W'(N_INP - 1)) ? '0 : sel + 1'b1;
`ifdef STREAM_RR_SCHED_LOCK_EN
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        // A stall and a handshake are mutually exclusive since both depend on oup_ready_i.
        if (state_q == ARB && oup_valid_o && !oup_ready_i) begin
            state_d    = LOCKED;
            lock_idx_d = sel;
        end else if (state_q == LOCKED && hs) begin
            state_d = ARB;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
`ifdef STREAM_RR_SCHED_LOCK_EN
            state_q    <= ARB;
            lock_idx_q <= '0;
`endif
        end else begin
            rr_q       <= rr_d;
`ifdef STREAM_RR_SCHED_LOCK_EN
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end
endmodule

// File: tb/tb_stream_rr_sched.sv
// tb_stream_rr_sched: checks stream_rr_sched (4 inputs, byte payload) against a round-robin model.
module tb_stream_rr_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   data [N];
    logic [N-1:0] valid = '0;
    logic [N-1:0] rdy_o;
    logic         ready = 1'b0;
    logic [7:0]   odata;
    logic         ovalid;
    logic [1:0]   oidx;

    int nerr = 0;
    int nchk = 0;
    int m_rr = 0;
    int hs_idx = -1;
`ifdef STREAM_RR_SCHED_LOCK_EN
    bit m_lk = 1'b0;
    int m_li = 0;
`endif

    stream_rr_sched #(.DATA_T(logic [7:0]), .N_INP(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .inp_data_i  (data),
        .inp_valid_i (valid),
        .inp_ready_o (rdy_o),
        .oup_data_o  (odata),
        .oup_valid_o (ovalid),
        .oup_ready_i (ready),
        .oup_idx_o   (oidx)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Round-robin choice: lowest distance (m_rr + i) mod N among valid inputs.
    function automatic int model_sel();
        int s = m_rr;
        for (int i = N - 1; i >= 0; i--)
            if (valid[2'((m_rr + i) % N)]) s = (m_rr + i) % N;
`ifdef STREAM_RR_SCHED_LOCK_EN
        if (m_lk) s = m_li;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        int  s;
        logic hs;
        if (rst) begin
            m_rr = 0;
`ifdef STREAM_RR_SCHED_LOCK_EN
            m_lk = 1'b0;
`endif
        end
        s = model_sel();
        chk("idx", 32'(oidx), 32'(s));
        chk("valid", 32'(ovalid), 32'(valid[2'(s)]));
        chk("data", 32'(odata), 32'(data[2'(s)]));
        chk("inp_ready", 32'(rdy_o), ready ? (32'd1 << s) : 32'd0);
        hs     = valid[2'(s)] && ready;
        hs_idx = hs ? s : -1;
        if (!rst) begin
            if (hs) m_rr = (s + 1) % N;
`ifdef STREAM_RR_SCHED_LOCK_EN
            if (!m_lk && valid[2'(s)] && !ready) begin
                m_lk = 1'b1;
                m_li = s;
            end else if (m_lk && hs) begin
                m_lk = 1'b0;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string n, int e);
        @(negedge clk);
        #1;
        chk(n, 32'(oidx), 32'(e));
        tick();
    endtask

    task automatic do_rst();
        valid = '0;
        ready = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) data[k] = 8'(16 + k);
        @(negedge clk);
        #1;
        chk("rst_idx", 32'(oidx), 32'd0);
        chk("rst_valid", 32'(ovalid), 32'd0);
        chk("rst_ready", 32'(rdy_o), 32'd0);
        tick();
        rst = 1'b0;

        valid = '1;
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("all_valid_idx", 32'(oidx), 32'(c % N));
            chk("all_valid_data", 32'(odata), 32'(16 + c % N));
            tick();
        end
        do_rst();

        ready = 1'b1;
        valid = 4'b0010;
        lit("rr_to2_pre", 1);
        valid = 4'b1010;
        lit("rr2_grant3", 3);
        valid = 4'b0010;
        lit("rr0_grant1", 1);
        valid = 4'b1111;
        lit("rr_back_to2", 2);
        do_rst();

`ifdef STREAM_RR_SCHED_LOCK_EN
        valid = 4'b0100;
        lit("lock_c0", 2);
        valid = 4'b0101;
        lit("lock_c1", 2);
        lit("lock_c2", 2);
        ready = 1'b1;
        @(negedge clk);
        #1;
        chk("lock_hs_ready", 32'(rdy_o), 32'h4);
        lit("lock_hs", 2);
        valid = 4'b0001;
        lit("after_lock_next", 0);
        do_rst();

        valid = 4'b0100;
        lit("drop_lock", 2);
        valid = 4'b0000;
        ready = 1'b1;
        @(negedge clk);
        #1;
        chk("drop_valid", 32'(ovalid), 32'd0);
        chk("drop_ready", 32'(rdy_o), 32'h4);
        lit("drop_idx", 2);
        valid = 4'b0001;
        lit("drop_still_locked", 2);
        do_rst();

        valid = 4'b1000;
        lit("rst_lock3", 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_lock_idx", 32'(oidx), 32'd3);
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        lit("rst_lock_hs", 3);
        valid = 4'b1001;
        lit("rst_lock_rr0", 0);
        do_rst();
`else
        valid = 4'b1000;
        lit("nolock_a", 3);
        valid = 4'b1010;
        lit("nolock_switch", 1);
        do_rst();
`endif

        repeat (3000) begin
            for (int k = 0; k < N; k++) begin
                if (hs_idx == k) begin
                    valid[k] = 1'b0;
                end else if (valid[k] && $urandom_range(63) == 0) begin
                    valid[k] = 1'b0;
                end else if (!valid[k] && $urandom_range(2) == 0) begin
                    valid[k] = 1'b1;
                    data[k]  = 8'($urandom);
                end
            end
            ready = ($urandom_range(3) != 0);
            rst   = ($urandom_range(199) == 0);
            tick();
        end
        rst   = 1'b0;
        valid = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
